// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side load/store front end for a word-wide DataMemory.
// Sub-word stores use read-modify-write. Define ALIGN_CHECK_EN to flag misaligned half/word accesses.
module load_store_unit #(
  parameter int N = 32
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Req,
  input  logic         WrReq,
  input  logic [1:0]   Size,
  input  logic         Unsigned,
  input  logic [N-1:0] Addr,
  input  logic [N-1:0] WData,
  output logic [N-1:0] RData,
  output logic         Done,
  output logic         Stall,
  output logic         Err,
  output logic [N-1:0] MemAdr,
  output logic [N-1:0] MemWData,
  output logic         MemWrEn,
  input  logic [N-1:0] MemRData
);

  // state    | meaning
  // S_IDLE   | waiting for Req; also the one-cycle error response slot
  // S_LOAD   | word read, lane extract/extend, Done
  // S_WR     | full-word store, Done
  // S_RMW_RD | read old word for a sub-word store
  // S_RMW_WR | write merged word, Done
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   size_q, size_d;
  logic         uns_q, uns_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] old_q, old_d;
  logic         err_q, err_d;

  logic         bad_align;
  logic [7:0]   lane_byte;
  logic [15:0]  lane_half;
  logic [N-1:0] load_ext;
  logic [N-1:0] merged;
  logic [N-1:0] word_adr;

`ifdef ALIGN_CHECK_EN
  assign bad_align = ((Size == 2'b01) & Addr[0]) | (Size[1] & (Addr[1:0] != 2'b00));
  assign Err       = err_q;
`else
  assign bad_align = 1'b0;
  assign Err       = 1'b0;
`endif

  assign word_adr = {addr_q[N-1:2], 2'b00};
  assign Stall    = Req & ~Done;

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_byte = MemRData[7:0];
      2'd1:    lane_byte = MemRData[15:8];
      2'd2:    lane_byte = MemRData[23:16];
      default: lane_byte = MemRData[31:24];
    endcase
    lane_half = addr_q[1] ? MemRData[31:16] : MemRData[15:0];
    case (size_q)
      2'b00:   load_ext = uns_q ? {{(N-8){1'b0}}, lane_byte}
                                : {{(N-8){lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = uns_q ? {{(N-16){1'b0}}, lane_half}
                                : {{(N-16){lane_half[15]}}, lane_half};
      default: load_ext = MemRData;
    endcase
  end

  // Replace only the addressed lane of the word captured in S_RMW_RD.
  always_comb begin
    merged = old_q;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    old_d    = old_q;
    err_d    = 1'b0;
    Done     = 1'b0;
    RData    = '0;
    MemAdr   = '0;
    MemWData = '0;
    MemWrEn  = 1'b0;
    case (state_q)
      S_IDLE: begin
        Done = err_q;
        // The error-response cycle is the Done cycle, so Req is not sampled in it.
        if (Req && !err_q) begin
          size_d  = Size;
          uns_d   = Unsigned;
          addr_d  = Addr;
          wdata_d = WData;
          if (bad_align)     err_d   = 1'b1;
          else if (!WrReq)   state_d = S_LOAD;
          else if (Size[1])  state_d = S_WR;
          else               state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        MemAdr  = word_adr;
        RData   = load_ext;
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      S_WR: begin
        MemAdr   = word_adr;
        MemWData = wdata_q;
        MemWrEn  = 1'b1;
        Done     = 1'b1;
        state_d  = S_IDLE;
      end
      S_RMW_RD: begin
        MemAdr  = word_adr;
        old_d   = MemRData;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        MemAdr   = word_adr;
        MemWData = merged;
        MemWrEn  = 1'b1;
        Done     = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      err_q   <= err_d;
    end
  end

endmodule
